// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed when the op is accepted and held in a pending register.
// busy stays high for a fixed latency, then the pending value is committed to HI/LO.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when the
// MD_UNIT_MAC_EN macro is defined.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MAC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic [WIDTH-1:0]   a_mag, b_mag, den, q_mag, r_mag, quo, rem;
  logic               sgn, div_ovf;

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Signed/unsigned products and magnitude-based divide (truncation toward zero).
  always_comb begin
    prod_s  = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
    prod_u  = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
    sgn     = (op == OP_DIV);
    a_mag   = (sgn && rs[WIDTH-1]) ? -rs : rs;
    b_mag   = (sgn && rt[WIDTH-1]) ? -rt : rt;
    // A zero divisor is replaced by one so the divider never sees x; the
    // divide-by-zero result is selected separately below.
    den     = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag   = a_mag / den;
    r_mag   = a_mag % den;
    quo     = (sgn && (rs[WIDTH-1] ^ rt[WIDTH-1])) ? -q_mag : q_mag;
    rem     = (sgn && rs[WIDTH-1]) ? -r_mag : r_mag;
    div_ovf = sgn && (rs == {1'b1, {(WIDTH-1){1'b0}}}) && (rt == '1);
  end

  // Select the pending result for the op presented this cycle.
  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV, OP_DIVU: begin
        if (rt == '0)   res = {rs, {WIDTH{1'b1}}};
        else if (div_ovf) res = {{WIDTH{1'b0}}, rs};
        else            res = {rem, quo};
      end
`ifdef MD_UNIT_MAC_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res = '0;
    endcase
  end

  // Next-state: accept ops in IDLE, count down in RUN, cancel overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                pend_d  = res;
                cnt_d   = MULT_LOAD;
                state_d = RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_d  = res;
                cnt_d   = DIV_LOAD;
                state_d = RUN;
              end
`ifdef MD_UNIT_MAC_EN
              OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                pend_d  = res;
                cnt_d   = MULT_LOAD;
                state_d = RUN;
              end
`endif
              OP_MTHI: hi_d = rs;
              OP_MTLO: lo_d = rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            hi_d    = pend_q[2*WIDTH-1:WIDTH];
            lo_d    = pend_q[WIDTH-1:0];
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, countdown, pending and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed cases plus randomized ops against a
// reference model written with plain integer arithmetic.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              si, ti;
    logic [63:0]     acc;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    acc = {h, l};
    case (o)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
        si = $signed(a);
        ti = $signed(b);
        return {32'(si % ti), 32'(si / ti)};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      4'd5: return {a, l};
      4'd6: return {h, a};
`ifdef MD_UNIT_MAC_EN
      4'd7:  return acc + 64'(sa * sb);
      4'd8:  return acc + 64'(ua * ub);
      4'd9:  return acc - 64'(sa * sb);
      4'd10: return acc - 64'(ua * ub);
`endif
      default: return acc;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] o);
    if (o >= 4'd1 && o <= 4'd2) return MC;
    if (o >= 4'd3 && o <= 4'd4) return DC;
`ifdef MD_UNIT_MAC_EN
    if (o >= 4'd7 && o <= 4'd10) return MC;
`endif
    return 0;
  endfunction

  // Issue one op, check busy and HI/LO each cycle, then the committed result.
  // Inputs are scrambled while busy to show they are ignored.
  task automatic exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int n;
    exp = model(o, a, b, m_hi, m_lo);
    n   = latency(o);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check($sformatf("%s_busy%0d", tag, i), 64'(busy), 64'd1);
      check($sformatf("%s_hold%0d", tag, i), {hi, lo}, {m_hi, m_lo});
      start = 1'($urandom_range(0, 1));
      op    = 4'($urandom_range(0, 15));
      rs    = $urandom;
      rt    = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s_idle", tag), 64'(busy), 64'd0);
    check($sformatf("%s_hilo", tag), {hi, lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 4'd0; rs = '0; rt = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT signed product
    exec(4'd1, 32'hFFFFFFFE, 32'd3, "mult");
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    // DIV truncation toward zero
    exec(4'd3, 32'hFFFFFFF9, 32'd2, "div");
    check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    // DIVU by zero
    exec(4'd4, 32'd7, 32'd0, "divu0");
    check("divu0_const", {hi, lo}, 64'h00000007_FFFFFFFF);
    // DIV signed overflow
    exec(4'd3, 32'h80000000, 32'hFFFFFFFF, "divovf");
    check("divovf_const", {hi, lo}, 64'h00000000_80000000);
    // DIV by zero, signed
    exec(4'd3, 32'h80000005, 32'd0, "div0");
    // MTHI / MTLO
    exec(4'd5, 32'h00001234, 32'd0, "mthi");
    check("mthi_const", 64'(hi), 64'h1234);
    exec(4'd6, 32'h00005678, 32'd0, "mtlo");
    // ignored ops
    exec(4'd0, 32'hDEADBEEF, 32'd1, "nop");
    exec(4'd11, 32'hDEADBEEF, 32'd1, "op11");
    exec(4'd15, 32'hDEADBEEF, 32'd1, "op15");

    // Cancel mid-run; a start while busy is ignored.
    @(negedge clk);
    start = 1'b1; op = 4'd2; rs = 32'd2; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("cancel_busy1", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b1; op = 4'd3; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("cancel_busy4", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_idle", 64'(busy), 64'd0);
    check("cancel_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (DC + 2) @(negedge clk);
    check("cancel_nocommit", {hi, lo}, {m_hi, m_lo});
    check("cancel_stay_idle", 64'(busy), 64'd0);

    // Cancel on the completion edge wins.
    @(negedge clk);
    start = 1'b1; op = 4'd1; rs = 32'd9; rt = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (MC - 1) @(negedge clk);
    check("cancel_last_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_last_idle", 64'(busy), 64'd0);
    check("cancel_last_hilo", {hi, lo}, {m_hi, m_lo});

    // Cancel beats a start on the same edge.
    start = 1'b1; cancel = 1'b1; op = 4'd1; rs = 32'd5; rt = 32'd5;
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 4'd5; rs = 32'hABCD;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", 64'(busy), 64'd0);
    check("cancel_start_hilo", {hi, lo}, {m_hi, m_lo});

    // Accumulate op: applied with the macro, ignored without it.
    exec(4'd5, 32'd0, 32'd0, "mac_sethi");
    exec(4'd6, 32'hFFFFFFFF, 32'd0, "mac_setlo");
    exec(4'd8, 32'd1, 32'd1, "maddu");
`ifdef MD_UNIT_MAC_EN
    check("maddu_const", {hi, lo}, 64'h00000001_00000000);
`else
    check("maddu_const", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    // Randomized ops against the model.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 6) ro = 4'($urandom_range(1, 4));
      else                          ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 15))
        0, 1: rb = 32'd0;
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      exec(ro, ra, rb, $sformatf("rnd%0d_op%0d", k, ro));
    end

    // Asynchronous reset mid-run clears everything without a clock edge.
    exec(4'd5, 32'hAAAA5555, 32'd0, "pre_rst_hi");
    exec(4'd6, 32'h5555AAAA, 32'd0, "pre_rst_lo");
    @(negedge clk);
    start = 1'b1; op = 4'd3; rs = 32'd1000; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (DC + 2) @(negedge clk);
    check("arst_after_busy", 64'(busy), 64'd0);
    check("arst_after_hilo", {hi, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
